// File: rtl/dmux_pkg.sv
// Shared constants and helpers for the buffered N-way demultiplexer.
package dmux_pkg;

  localparam int DEF_N     = 8;
  localparam int DEF_W     = 16;
  localparam int DEF_DEPTH = 4;

  // Ceiling log2, usable in constant expressions; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dmux_nway_buf_if.sv
// Input stream plus per-channel output streams of the demultiplexer.
interface dmux_nway_buf_if #(
  parameter int N = dmux_pkg::DEF_N,
  parameter int W = dmux_pkg::DEF_W
);
  localparam int SEL_W = dmux_pkg::clog2(N);

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic [SEL_W-1:0] in_sel;
  logic             in_bcast;
  logic [N-1:0]     out_valid;
  logic [N-1:0]     out_ready;
  logic [N*W-1:0]   out_data;
  logic             err_sel;

  // Producer and consumers drive the master side; the demultiplexer is the slave.
  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_valid, out_data, err_sel
  );

  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_valid, out_data, err_sel
  );

endinterface

// File: rtl/dmux_chan_fifo.sv
// Single output channel FIFO. Pointers and count reset; storage does not.
module dmux_chan_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head_data
);
  localparam int PW = dmux_pkg::clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  // A pop on an empty channel is ignored, so an empty push+pop leaves count = 1.
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Word storage, written at the tail.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dmux_nway_buf.sv
// Buffered N-way demultiplexer: unicast or all-or-nothing broadcast into
// per-channel FIFOs; out-of-range selectors are consumed and flagged.
module dmux_nway_buf
  import dmux_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int W     = DEF_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic             clk,
  input logic             reset,
  dmux_nway_buf_if.slave  bus
);
  localparam int SEL_W = clog2(N);
  localparam logic [SEL_W:0] N_L = (SEL_W + 1)'(N);

  logic [N-1:0]   full;
  logic [N-1:0]   empty;
  logic [N-1:0]   push;
  logic [N-1:0]   pop;
  logic [N*W-1:0] head;
  logic           sel_oob;
  logic           accept;

  assign sel_oob       = !bus.in_bcast && ({1'b0, bus.in_sel} >= N_L);
  assign accept        = bus.in_valid && bus.in_ready;
  assign pop           = ~empty & bus.out_ready;
  assign bus.out_valid = ~empty;
  assign bus.out_data  = head;

  // Readiness depends only on occupancy and the selector, never on out_ready.
  always_comb begin
    bus.in_ready = 1'b0;
    if (!reset) begin
      if (bus.in_bcast)  bus.in_ready = &(~full);
      else if (sel_oob)  bus.in_ready = 1'b1;
      else               bus.in_ready = !full[bus.in_sel];
    end
  end

  // Push decode: one channel for unicast, every channel for broadcast.
  always_comb begin
    push = '0;
    if (accept && !sel_oob) begin
      if (bus.in_bcast) push = '1;
      else              push[bus.in_sel] = 1'b1;
    end
  end

  // One-cycle flag for a dropped out-of-range word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bus.err_sel <= 1'b0;
    else       bus.err_sel <= accept && sel_oob;
  end

  for (genvar k = 0; k < N; k++) begin : g_chan
    dmux_chan_fifo #(
      .W     (W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push[k]),
      .push_data (bus.in_data),
      .pop       (pop[k]),
      .full      (full[k]),
      .empty     (empty[k]),
      .head_data (head[k*W +: W])
    );
  end

endmodule
